// File: rtl/box_draw_sched.sv
// Round-robin scheduler sharing one box-drawer datapath among NREQ sprite requesters.
// Steps the datapath row by row, one plot strobe per pixel, and pulses done to the winner.
// Optional job watchdog: define BOX_SCHED_WDOG_EN to abort jobs after WDOG_CYCLES busy cycles.
module box_draw_sched #(
  parameter int unsigned NREQ        = 3,
  parameter int unsigned WDOG_CYCLES = 8191
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] done,
  output logic            busy,
  input  logic            x_done,
  input  logic            y_done,
  output logic            dp_reset,
  output logic            dp_set,
  output logic            dp_setx,
  output logic            dp_sety,
  output logic            dp_x_en,
  output logic            dp_y_en,
  output logic            dp_resetX,
  output logic            plot,
  output logic            err
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W = 13;

  // Reject configurations the round-robin pointer or the 13-bit job counter cannot hold
  if (NREQ < 2 || NREQ > 8 || WDOG_CYCLES == 0 || WDOG_CYCLES > 8191) begin : g_param_check
    $error("box_draw_sched: NREQ or WDOG_CYCLES out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETXY,
    S_PLOT,
    S_STEPX,
    S_NEXTROW,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   pick_c;
  logic               found_c;

  logic [NREQ-1:0]    grant_q, grant_d;
  logic [NREQ-1:0]    done_q, done_d;
  logic               busy_q, busy_d;
  logic               dp_reset_q, dp_reset_d;
  logic               dp_set_q, dp_set_d;
  logic               dp_setx_q, dp_setx_d;
  logic               dp_sety_q, dp_sety_d;
  logic               dp_x_en_q, dp_x_en_d;
  logic               dp_y_en_q, dp_y_en_d;
  logic               dp_resetx_q, dp_resetx_d;
  logic               plot_q, plot_d;

`ifdef BOX_SCHED_WDOG_EN
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               abort_c;
  logic               err_q, err_d;
`endif

  // First requester at or above the round-robin pointer, wrapping at NREQ
  always_comb begin
    int unsigned idx;
    found_c = 1'b0;
    pick_c  = '0;
    idx     = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found_c && req[IDX_W'(idx)]) begin
        found_c = 1'b1;
        pick_c  = IDX_W'(idx);
      end
    end
  end

  // Next state, winner/pointer bookkeeping and Moore outputs derived from the next state
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    rr_d    = rr_q;
`ifdef BOX_SCHED_WDOG_EN
    abort_c = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (found_c) begin
          win_d   = pick_c;
          state_d = S_LOAD;
        end
      end
      S_LOAD:    state_d = S_SETXY;
      S_SETXY:   state_d = S_PLOT;
      S_PLOT: begin
        if (y_done)      state_d = S_DONE;
        else if (x_done) state_d = S_NEXTROW;
        else             state_d = S_STEPX;
      end
      S_STEPX:   state_d = S_SETXY;
      S_NEXTROW: state_d = S_SETXY;
      S_DONE: begin
        rr_d    = (32'(win_q) == NREQ - 1) ? '0 : win_q + IDX_W'(1);
        state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
`ifdef BOX_SCHED_WDOG_EN
    // Job overran its cycle budget: force completion next cycle
    if (state_q != S_IDLE && state_q != S_DONE && cnt_q >= CNT_W'(WDOG_CYCLES - 1)) begin
      state_d = S_DONE;
      abort_c = 1'b1;
    end
`endif

    grant_d     = '0;
    done_d      = '0;
    busy_d      = (state_d != S_IDLE);
    dp_reset_d  = (state_d != S_IDLE) && (state_d != S_LOAD);
    dp_set_d    = (state_d == S_LOAD);
    dp_setx_d   = (state_d == S_SETXY);
    dp_sety_d   = (state_d == S_SETXY);
    dp_x_en_d   = (state_d == S_STEPX);
    dp_y_en_d   = (state_d == S_NEXTROW);
    dp_resetx_d = (state_d == S_NEXTROW);
    plot_d      = (state_d == S_PLOT);
    if (state_d != S_IDLE) grant_d[win_d] = 1'b1;
    if (state_d == S_DONE) done_d[win_d]  = 1'b1;
`ifdef BOX_SCHED_WDOG_EN
    err_d = abort_c;
`endif
  end

  // State, arbitration and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      win_q       <= '0;
      rr_q        <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      dp_reset_q  <= 1'b0;
      dp_set_q    <= 1'b0;
      dp_setx_q   <= 1'b0;
      dp_sety_q   <= 1'b0;
      dp_x_en_q   <= 1'b0;
      dp_y_en_q   <= 1'b0;
      dp_resetx_q <= 1'b0;
      plot_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      dp_reset_q  <= dp_reset_d;
      dp_set_q    <= dp_set_d;
      dp_setx_q   <= dp_setx_d;
      dp_sety_q   <= dp_sety_d;
      dp_x_en_q   <= dp_x_en_d;
      dp_y_en_q   <= dp_y_en_d;
      dp_resetx_q <= dp_resetx_d;
      plot_q      <= plot_d;
    end
  end

`ifdef BOX_SCHED_WDOG_EN
  // Saturating job cycle counter, zero during LOAD
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == S_LOAD)                      cnt_d = '0;
    else if (state_q != S_IDLE && cnt_q != '1)  cnt_d = cnt_q + CNT_W'(1);
  end

  // Watchdog counter and abort flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign dp_reset  = dp_reset_q;
  assign dp_set    = dp_set_q;
  assign dp_setx   = dp_setx_q;
  assign dp_sety   = dp_sety_q;
  assign dp_x_en   = dp_x_en_q;
  assign dp_y_en   = dp_y_en_q;
  assign dp_resetX = dp_resetx_q;
  assign plot      = plot_q;

endmodule

// File: tb/tb_box_draw_sched.sv
// Self-checking bench for box_draw_sched: behavioural k x k datapath, round-robin
// reference model and expected per-cycle strobe sequences built from the job shape.
module tb_box_draw_sched;

  localparam int NREQ = 3;
  localparam int WDOG = 20;
`ifdef BOX_SCHED_WDOG_EN
  localparam int KMAX = 2;
`else
  localparam int KMAX = 3;
`endif

  logic            clk;
  logic            reset;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant, done;
  logic            busy, x_done, y_done;
  logic            dp_reset, dp_set, dp_setx, dp_sety, dp_x_en, dp_y_en, dp_resetX, plot, err;

  box_draw_sched #(.NREQ(NREQ), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .reset(reset), .req(req), .grant(grant), .done(done), .busy(busy),
    .x_done(x_done), .y_done(y_done), .dp_reset(dp_reset), .dp_set(dp_set),
    .dp_setx(dp_setx), .dp_sety(dp_sety), .dp_x_en(dp_x_en), .dp_y_en(dp_y_en),
    .dp_resetX(dp_resetX), .plot(plot), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int rr_m  = 0;

  // Behavioural box datapath
  int k_cur   = 1;
  bit y_stuck = 1'b0;
  int col = 0;
  int row = 0;
  always @(posedge clk) begin
    if (dp_set) begin
      col <= 0;
      row <= 0;
    end else begin
      if (dp_resetX)    col <= 0;
      else if (dp_x_en) col <= col + 1;
      if (dp_y_en)      row <= row + 1;
    end
  end
  assign x_done = (col == k_cur - 1);
  assign y_done = x_done && (row == k_cur - 1) && !y_stuck;

  // Observations of one job
  int seq_q[$];
  int exp_q[$];
  logic [NREQ-1:0] o_g0, o_dval;
  int o_lat, o_gcyc, o_nplot, o_dcyc, o_nerr, o_ecyc, o_gbad;
  bit o_tmo;

  // 1 LOAD, 2 SETXY, 3 PLOT, 4 STEPX, 5 NEXTROW, 6 DONE, 0 illegal strobe mix
  function automatic int strobe_code();
    logic [7:0] s;
    s = {dp_set, dp_setx, dp_sety, plot, dp_x_en, dp_y_en, dp_resetX, |done};
    case (s)
      8'b1000_0000: return dp_reset ? 0 : 1;
      8'b0110_0000: return dp_reset ? 2 : 0;
      8'b0001_0000: return dp_reset ? 3 : 0;
      8'b0000_1000: return dp_reset ? 4 : 0;
      8'b0000_0110: return dp_reset ? 5 : 0;
      8'b0000_0001: return dp_reset ? 6 : 0;
      default:      return 0;
    endcase
  endfunction

  // Expected job: load, every pixel set+plot, a step between pixels, then done
  task automatic build_exp(input int k);
    exp_q.delete();
    exp_q.push_back(1);
    for (int p = 0; p < k * k; p++) begin
      exp_q.push_back(2);
      exp_q.push_back(3);
      if (p != k * k - 1) exp_q.push_back(((p % k) == k - 1) ? 5 : 4);
    end
    exp_q.push_back(6);
  endtask

  function automatic bit seq_match();
    if (seq_q.size() != exp_q.size()) return 1'b0;
    foreach (seq_q[i]) if (seq_q[i] != exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int model_pick(input logic [NREQ-1:0] r);
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = (rr_m + i) % NREQ;
      if (((r >> j) & NREQ'(1)) != '0) return j;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    return NREQ'(1) << i;
  endfunction

  // Follow one job from the current negedge until grant falls
  task automatic observe_job(input int drop_at, input logic [NREQ-1:0] mid_req);
    o_lat = 0; o_gcyc = 0; o_nplot = 0; o_dcyc = 0; o_dval = '0;
    o_nerr = 0; o_ecyc = 0; o_gbad = 0; o_tmo = 1'b0;
    seq_q.delete();
    while (grant == '0 && !o_tmo) begin
      @(negedge clk);
      o_lat++;
      if (o_lat > 20) o_tmo = 1'b1;
    end
    o_g0 = grant;
    while (grant != '0 && !o_tmo) begin
      o_gcyc++;
      seq_q.push_back(strobe_code());
      if (plot) o_nplot++;
      if (done != '0) begin
        if (o_dcyc != 0) o_gbad++;
        o_dcyc = o_gcyc;
        o_dval = done;
      end
      if (err) begin o_nerr++; o_ecyc = o_gcyc; end
      if (grant !== o_g0 || busy !== 1'b1) o_gbad++;
      if (o_gcyc == drop_at) req = mid_req;
      @(negedge clk);
      if (o_gcyc > 400) o_tmo = 1'b1;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    req   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    rr_m  = 0;
  endtask

  task automatic test_reset();
    logic [16:0] outs;
    reset = 1'b0;
    req   = '0;
    repeat (3) @(negedge clk);
    outs = {grant, done, busy, dp_reset, dp_set, dp_setx, dp_sety, dp_x_en, dp_y_en, dp_resetX, plot, err};
    n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL reset_outputs: got %b want 0", outs); end
    reset = 1'b1;
    rr_m  = 0;
    @(negedge clk);
    outs = {grant, done, busy, dp_reset, dp_set, dp_setx, dp_sety, dp_x_en, dp_y_en, dp_resetX, plot, err};
    n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL idle_outputs: got %b want 0", outs); end
  endtask

  task automatic test_single_pixel();
    int w;
    req = 3'b001; k_cur = 1;
    w = model_pick(req);
    build_exp(1);
    observe_job(0, '0);
    req = '0;
    n_cmp++; if (o_tmo) begin n_bad++; $display("FAIL t1_timeout: got 1 want 0"); end
    n_cmp++; if (o_lat !== 1) begin n_bad++; $display("FAIL t1_grant_latency: got %0d want 1", o_lat); end
    n_cmp++; if (o_g0 !== onehot(w)) begin n_bad++; $display("FAIL t1_grant: got %b want %b", o_g0, onehot(w)); end
    n_cmp++; if (o_gcyc !== 4) begin n_bad++; $display("FAIL t1_grant_cycles: got %0d want 4", o_gcyc); end
    n_cmp++; if (o_nplot !== 1) begin n_bad++; $display("FAIL t1_plots: got %0d want 1", o_nplot); end
    n_cmp++; if (o_dcyc !== 4 || o_dval !== 3'b001) begin n_bad++; $display("FAIL t1_done: got cyc %0d val %b want cyc 4 val 001", o_dcyc, o_dval); end
    n_cmp++; if (!seq_match()) begin n_bad++; $display("FAIL t1_sequence: got %p want %p", seq_q, exp_q); end
    rr_m = (w + 1) % NREQ;
  endtask

  task automatic test_multi_pixel();
    int w;
    req = 3'b001; k_cur = 2;
    w = model_pick(req);
    build_exp(2);
    observe_job(0, '0);
    req = '0;
    n_cmp++; if (o_tmo) begin n_bad++; $display("FAIL t2_timeout: got 1 want 0"); end
    n_cmp++; if (o_gcyc !== 13) begin n_bad++; $display("FAIL t2_grant_cycles: got %0d want 13", o_gcyc); end
    n_cmp++; if (o_nplot !== 4) begin n_bad++; $display("FAIL t2_plots: got %0d want 4", o_nplot); end
    n_cmp++; if (!seq_match()) begin n_bad++; $display("FAIL t2_sequence: got %p want %p", seq_q, exp_q); end
    n_cmp++; if (o_dval !== onehot(w) || o_gbad !== 0) begin n_bad++; $display("FAIL t2_done_grant: got done %b glitches %0d want %b 0", o_dval, o_gbad, onehot(w)); end
    rr_m = (w + 1) % NREQ;
  endtask

  task automatic test_back_to_back();
    int w;
    apply_reset();
    req = 3'b111; k_cur = 1;
    for (int j = 0; j < 4; j++) begin
      w = model_pick(req);
      observe_job(0, '0);
      n_cmp++; if (o_tmo || o_g0 !== onehot(w)) begin n_bad++; $display("FAIL t3_order%0d: got %b want %b", j, o_g0, onehot(w)); end
      n_cmp++; if (o_lat !== 1) begin n_bad++; $display("FAIL t3_gap%0d: got %0d want 1", j, o_lat); end
      n_cmp++; if (o_dval !== onehot(w) || o_dcyc !== 4) begin n_bad++; $display("FAIL t3_done%0d: got %b at %0d want %b at 4", j, o_dval, o_dcyc, onehot(w)); end
      rr_m = (w + 1) % NREQ;
    end
    req = '0;
  endtask

  task automatic test_req_drop();
    int w;
    req = 3'b010; k_cur = KMAX;
    w = model_pick(req);
    build_exp(KMAX);
    observe_job(2, 3'b000);
    n_cmp++; if (o_tmo || o_g0 !== onehot(w)) begin n_bad++; $display("FAIL t4_grant: got %b want %b", o_g0, onehot(w)); end
    n_cmp++; if (o_nplot !== KMAX * KMAX) begin n_bad++; $display("FAIL t4_plots: got %0d want %0d", o_nplot, KMAX * KMAX); end
    n_cmp++; if (o_dval !== 3'b010 || o_gcyc !== 3 * KMAX * KMAX + 1) begin n_bad++; $display("FAIL t4_done: got %b len %0d want 010 len %0d", o_dval, o_gcyc, 3 * KMAX * KMAX + 1); end
    rr_m = (w + 1) % NREQ;
  endtask

  task automatic test_reset_mid_job();
    int w, np, cyc;
    logic [16:0] outs;
    req = 3'b110; k_cur = 3;
    w = model_pick(req);
    np = 0; cyc = 0;
    while (np < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (plot) np++;
    end
    n_cmp++; if (np !== 3 || grant !== onehot(w)) begin n_bad++; $display("FAIL t5_pre_reset: got plots %0d grant %b want 3 %b", np, grant, onehot(w)); end
    reset = 1'b0;
    #1;
    outs = {grant, done, busy, dp_reset, dp_set, dp_setx, dp_sety, dp_x_en, dp_y_en, dp_resetX, plot, err};
    n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL t5_async_clear: got %b want 0", outs); end
    np = 0;
    repeat (3) begin
      @(negedge clk);
      if (done != '0 || busy) np++;
    end
    n_cmp++; if (np !== 0) begin n_bad++; $display("FAIL t5_held_in_reset: got %0d active cycles want 0", np); end
    reset = 1'b1;
    rr_m  = 0;
    w = model_pick(req);
    build_exp(3);
    observe_job(0, '0);
    req = '0;
    n_cmp++; if (o_tmo || o_g0 !== onehot(w)) begin n_bad++; $display("FAIL t5_restart_grant: got %b want %b", o_g0, onehot(w)); end
    n_cmp++; if (o_nplot !== 9 || !seq_match()) begin n_bad++; $display("FAIL t5_restart_job: got plots %0d seq %p", o_nplot, seq_q); end
    rr_m = (w + 1) % NREQ;
  endtask

  task automatic test_random();
    int w, k, drop_at, L;
    logic [NREQ-1:0] r, mid;
    for (int j = 0; j < 30; j++) begin
      r = NREQ'($urandom_range(1, 7));
      k = $urandom_range(1, KMAX);
      w = model_pick(r);
      L = 3 * k * k + 1;
      drop_at = $urandom_range(0, 3);
      mid = NREQ'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) mid = mid | onehot(w);
      else                           mid = mid & ~onehot(w);
      req = r; k_cur = k;
      build_exp(k);
      observe_job(drop_at, mid);
      req = '0;
      n_cmp++; if (o_tmo || o_g0 !== onehot(w)) begin n_bad++; $display("FAIL rnd%0d_grant: req %b got %b want %b", j, r, o_g0, onehot(w)); end
      n_cmp++; if (o_gcyc !== L || o_nplot !== k * k) begin n_bad++; $display("FAIL rnd%0d_len: got %0d/%0d want %0d/%0d", j, o_gcyc, o_nplot, L, k * k); end
      n_cmp++; if (o_dcyc !== L || o_dval !== onehot(w) || o_nerr !== 0 || o_gbad !== 0) begin n_bad++; $display("FAIL rnd%0d_done: got %b at %0d err %0d glitch %0d want %b at %0d", j, o_dval, o_dcyc, o_nerr, o_gbad, onehot(w), L); end
      n_cmp++; if (!seq_match()) begin n_bad++; $display("FAIL rnd%0d_sequence: got %p want %p", j, seq_q, exp_q); end
      rr_m = (w + 1) % NREQ;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_watchdog();
    int w;
    req = 3'b001; k_cur = 1; y_stuck = 1'b1;
    w = model_pick(req);
`ifdef BOX_SCHED_WDOG_EN
    observe_job(0, '0);
    req = '0;
    n_cmp++; if (o_tmo || o_gcyc !== WDOG + 1) begin n_bad++; $display("FAIL t6_abort_len: got %0d want %0d", o_gcyc, WDOG + 1); end
    n_cmp++; if (o_dcyc !== WDOG + 1 || o_dval !== onehot(w)) begin n_bad++; $display("FAIL t6_abort_done: got %b at %0d want %b at %0d", o_dval, o_dcyc, onehot(w), WDOG + 1); end
    n_cmp++; if (o_nerr !== 1 || o_ecyc !== WDOG + 1) begin n_bad++; $display("FAIL t6_abort_err: got %0d pulses at %0d want 1 at %0d", o_nerr, o_ecyc, WDOG + 1); end
    rr_m = (w + 1) % NREQ;
    y_stuck = 1'b0;
`else
    begin
      int cyc, hung;
      cyc = 0; hung = 0;
      while (grant == '0 && cyc < 20) begin @(negedge clk); cyc++; end
      n_cmp++; if (grant !== onehot(w)) begin n_bad++; $display("FAIL t6_grant: got %b want %b", grant, onehot(w)); end
      repeat (60) begin
        @(negedge clk);
        if (busy === 1'b1 && done == '0 && err === 1'b0) hung++;
      end
      n_cmp++; if (hung !== 60) begin n_bad++; $display("FAIL t6_hang: got %0d busy cycles want 60", hung); end
      y_stuck = 1'b0;
      apply_reset();
    end
`endif
  endtask

  initial begin
    reset = 1'b0;
    req   = '0;
    test_reset();
    test_single_pixel();
    test_multi_pixel();
    test_back_to_back();
    test_req_drop();
    test_reset_mid_job();
    test_random();
    test_watchdog();
    test_single_pixel();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got no end of run want finish");
    $fatal(1, "run did not finish");
  end

endmodule
